peri_bus_arbiter: RTL and testbench
===================================

Name: peri_bus_arbiter

Overview:
- Shares the single on-chip peripheral bus port (req/gnt/rvalid protocol) between NumMasters requesters, e.g. the core data port and a debug/DMA master.
- Sits between the core-complex address decode and the peripheral interconnect.
- Arbitration is round-robin with request locking until grant.
- An in-order ID FIFO tracks outstanding transactions so each response is routed back to its issuing master.

Parameters:
- NumMasters, 2, number of requesters (2..4).
- MaxOutstanding, 2, number of accepted-but-unanswered transactions allowed on the slave bus (1..4).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte enable width is DataWidth/8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m_req_i  in  NumMasters  per-master request.
- m_gnt_o  out  NumMasters  per-master grant.
- m_addr_i  in  NumMasters x AddrWidth  per-master address.
- m_we_i  in  NumMasters  per-master write enable.
- m_be_i  in  NumMasters x DataWidth/8  per-master byte enables.
- m_wdata_i  in  NumMasters x DataWidth  per-master write data.
- m_rvalid_o  out  NumMasters  per-master response valid.
- m_rdata_o  out  NumMasters x DataWidth  per-master read data.
- s_req_o  out  1  slave request.
- s_gnt_i  in  1  slave grant.
- s_addr_o  out  AddrWidth  slave address.
- s_we_o  out  1  slave write enable.
- s_be_o  out  DataWidth/8  slave byte enables.
- s_wdata_o  out  DataWidth  slave write data.
- s_rvalid_i  in  1  slave response valid.
- s_rdata_i  in  DataWidth  slave read data.
- err_o  out  1  sticky protocol error: rvalid received with no outstanding transaction.

Behaviour:
- Reset (async, rst_n low):
  - Round-robin pointer resets to 0.
  - Lock cleared, ID FIFO emptied, err_o = 0.
  - All outputs are combinational functions of this state and therefore read 0 during reset: s_req_o, m_gnt_o, m_rvalid_o, s_addr_o/we/be/wdata, m_rdata_o.
- Arbitration (combinational):
  - The winner is the first asserted m_req_i at or after the pointer, searching upward with wrap from NumMasters-1 to 0.
  - If a lock is held, the locked master wins regardless of the pointer.
- Issue:
  - s_req_o = winner exists AND ID FIFO not full.
  - s_addr_o/we/be/wdata = winner's fields, driven to 0 when s_req_o = 0.
  - m_gnt_o[winner] = s_gnt_i AND s_req_o; every other gnt bit is 0. Grant latency is zero cycles, combinational passthrough from s_gnt_i.
- Lock:
  - Set when s_req_o=1 and s_gnt_i=0; stores the winner index.
  - Cleared on the handshake (s_req_o & s_gnt_i). Required so the slave sees a stable request until accepted.
  - A locked master dropping m_req_i before grant is a master protocol violation; the lock clears and err_o is not set.
- Pointer: on each handshake, pointer <= (winner+1) mod NumMasters. No change otherwise.
- ID FIFO:
  - Depth MaxOutstanding, entries of index width clog2(NumMasters) (minimum 1).
  - Push winner index on handshake; pop on s_rvalid_i.
  - When full, issue is blocked even if a pop occurs in the same cycle. This is deterministic: at most MaxOutstanding transactions in flight.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - Pointers wrap modulo MaxOutstanding.
- Response:
  - On s_rvalid_i with FIFO non-empty: m_rvalid_o[head] = 1 and m_rdata_o[head] = s_rdata_i. All other masters get rvalid 0 and rdata 0.
  - Same-cycle latency, combinational.
- Stray response: s_rvalid_i with FIFO empty is dropped, no m_rvalid_o is asserted, and err_o is set to 1 and held until reset.
- Responses are strictly in order; the slave is required to respond in issue order.
- Reset mid-operation discards outstanding IDs; late responses after reset assert err_o.

Decomposition:
- Package peri_arb_pkg holds:
  - MaxMasters = 4 and MaxOutstandingLimit = 4 constants.
  - typedef for the master index: logic [1:0] mst_idx_t.
  - A packed struct for the request bundle {addr, we, be, wdata}.
- Sub-module peri_arb_id_fifo is the parameterised synchronous FIFO, with ports push, pop, wdata, rdata, full and empty, plus async reset.
- Arbitration, lock and response routing stay in the top level.

Test Plan:
- Single master: m_req_i=01, addr 0x100, s_gnt_i=1 same cycle, s_rvalid_i one cycle later with rdata 0xDEADBEEF -> m_gnt_o=01 in cycle 0; m_rvalid_o=01 and m_rdata_o[0]=0xDEADBEEF in cycle 1; pointer=1.
- Round-robin: both masters request continuously, s_gnt_i=1, rvalid after 1 cycle -> grants alternate 01,10,01,10. Slave addresses alternate m0/m1. Each rvalid reaches the correct master.
- Lock: m_req_i=01, s_gnt_i=0 for 3 cycles, m1 requests at cycle 1, grant in cycle 3 -> s_addr_o holds m0's address for cycles 0-3, m0 is granted at cycle 3, m1 is granted next.
- FIFO full: MaxOutstanding=2, two grants and no rvalid -> third request sees s_req_o=0 and m_gnt_o=00. After one rvalid, s_req_o reasserts the following cycle.
- Stray rvalid: s_rvalid_i=1 with the FIFO empty -> m_rvalid_o=00, err_o=1 and held until rst_n low, which clears it to 0.
- Reset mid-operation: rst_n asserted low with 2 transactions outstanding -> all outputs 0, FIFO empty, pointer 0; after release, a new request is granted normally.

Source files
------------

// File: rtl/peri_arb_pkg.sv
// Shared types and limits for the peripheral bus arbiter.
package peri_arb_pkg;

    localparam int MaxMasters          = 4;
    localparam int MaxOutstandingLimit = 4;

    // Field widths of the request bundle; the top level casts to its own widths.
    localparam int BusAddrWidth = 32;
    localparam int BusDataWidth = 32;

    typedef logic [1:0] mst_idx_t;

    // One master's request fields, as selected by the arbiter.
    typedef struct packed {
        logic [BusAddrWidth-1:0]   addr;
        logic                      we;
        logic [BusDataWidth/8-1:0] be;
        logic [BusDataWidth-1:0]   wdata;
    } req_bundle_t;

endpackage

// File: rtl/peri_arb_id_fifo.sv
// In-order FIFO of issuing-master indices for outstanding bus transactions.
module peri_arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers wrap at Depth-1; the count moves only when exactly one side acts.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Storage and pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/peri_bus_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid peripheral port between masters.
// Handshake: a request is accepted in the cycle where s_req_o and s_gnt_i are both
// high; an unaccepted request stays locked to its master until accepted, and each
// s_rvalid_i returns to the master at the head of the in-order ID FIFO.
module peri_bus_arbiter
    import peri_arb_pkg::*;
#(
    parameter int NumMasters     = 2,
    parameter int MaxOutstanding = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NumMasters-1:0]             m_req_i,
    output logic [NumMasters-1:0]             m_gnt_o,
    input  logic [NumMasters*AddrWidth-1:0]   m_addr_i,
    input  logic [NumMasters-1:0]             m_we_i,
    input  logic [NumMasters*DataWidth/8-1:0] m_be_i,
    input  logic [NumMasters*DataWidth-1:0]   m_wdata_i,
    output logic [NumMasters-1:0]             m_rvalid_o,
    output logic [NumMasters*DataWidth-1:0]   m_rdata_o,
    output logic                              s_req_o,
    input  logic                              s_gnt_i,
    output logic [AddrWidth-1:0]              s_addr_o,
    output logic                              s_we_o,
    output logic [DataWidth/8-1:0]            s_be_o,
    output logic [DataWidth-1:0]              s_wdata_o,
    input  logic                              s_rvalid_i,
    input  logic [DataWidth-1:0]              s_rdata_i,
    output logic                              err_o
);

    localparam int BeWidth = DataWidth / 8;
    localparam int IdxW    = (NumMasters > 1) ? $clog2(NumMasters) : 1;

    mst_idx_t        ptr_q, ptr_d;
    mst_idx_t        lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    mst_idx_t        win_idx;
    logic            win_valid;
    req_bundle_t     sel;
    logic            handshake;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [IdxW-1:0] fifo_head;

    // Winner: the locked master if it still requests, else first requester from the pointer.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        if (rst_n) begin
            if (lock_q) begin
                for (int i = 0; i < NumMasters; i++) begin
                    if (i == int'(lock_idx_q) && m_req_i[i]) begin
                        win_valid = 1'b1;
                        win_idx   = mst_idx_t'(i);
                    end
                end
            end
            if (!win_valid) begin
                // Scan farthest-first so the nearest requester is the last one written.
                for (int k = NumMasters - 1; k >= 0; k--) begin
                    for (int i = 0; i < NumMasters; i++) begin
                        if (i == (int'(ptr_q) + k) % NumMasters && m_req_i[i]) begin
                            win_valid = 1'b1;
                            win_idx   = mst_idx_t'(i);
                        end
                    end
                end
            end
        end
    end

    // Pick the winner's request fields.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NumMasters; i++) begin
            if (win_valid && i == int'(win_idx)) begin
                sel.addr  = BusAddrWidth'(m_addr_i[i*AddrWidth +: AddrWidth]);
                sel.we    = m_we_i[i];
                sel.be    = (BusDataWidth/8)'(m_be_i[i*BeWidth +: BeWidth]);
                sel.wdata = BusDataWidth'(m_wdata_i[i*DataWidth +: DataWidth]);
            end
        end
    end

    assign s_req_o   = win_valid & ~fifo_full;
    assign handshake = s_req_o & s_gnt_i;
    assign s_addr_o  = s_req_o ? AddrWidth'(sel.addr) : '0;
    assign s_we_o    = s_req_o & sel.we;
    assign s_be_o    = s_req_o ? BeWidth'(sel.be) : '0;
    assign s_wdata_o = s_req_o ? DataWidth'(sel.wdata) : '0;
    assign fifo_pop  = s_rvalid_i & ~fifo_empty;
    assign err_o     = err_q;

    // Grant passthrough to the winner and response routing to the FIFO head.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        for (int i = 0; i < NumMasters; i++) begin
            if (handshake && i == int'(win_idx)) begin
                m_gnt_o[i] = 1'b1;
            end
            if (rst_n && fifo_pop && i == int'(fifo_head)) begin
                m_rvalid_o[i]                    = 1'b1;
                m_rdata_o[i*DataWidth +: DataWidth] = s_rdata_i;
            end
        end
    end

    // Next-state for pointer, lock and sticky error.
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = s_req_o & ~s_gnt_i;
        lock_idx_d = lock_d ? win_idx : lock_idx_q;
        err_d      = err_q | (s_rvalid_i & fifo_empty);
        if (handshake) begin
            ptr_d = mst_idx_t'((int'(win_idx) + 1) % NumMasters);
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    peri_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (handshake),
        .pop_i   (fifo_pop),
        .wdata_i (IdxW'(win_idx)),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Bench for peri_bus_arbiter: directed vector table, hand sequences, random vs model.
module tb_peri_bus_arbiter;

    localparam int N  = 2;
    localparam int MO = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req_i, m_gnt_o, m_we_i, m_rvalid_o;
    logic [N*AW-1:0] m_addr_i;
    logic [N*BW-1:0] m_be_i;
    logic [N*DW-1:0] m_wdata_i, m_rdata_o;
    logic            s_req_o, s_gnt_i, s_we_o, s_rvalid_i, err_o;
    logic [AW-1:0]   s_addr_o;
    logic [BW-1:0]   s_be_o;
    logic [DW-1:0]   s_wdata_o, s_rdata_i;

    peri_bus_arbiter #(
        .NumMasters     (N),
        .MaxOutstanding (MO),
        .AddrWidth      (AW),
        .DataWidth      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req_i    (m_req_i),
        .m_gnt_o    (m_gnt_o),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .s_req_o    (s_req_o),
        .s_gnt_i    (s_gnt_i),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .err_o      (err_o)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                         input logic [DW-1:0] rdata);
        m_req_i    = req;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rdata;
    endtask

    task automatic fixed_fields();
        m_addr_i  = {32'h0000_0200, 32'h0000_0100};
        m_we_i    = 2'b01;
        m_be_i    = {4'h3, 4'hF};
        m_wdata_i = {32'h0000_00B1, 32'h0000_00A0};
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]  req;
        logic          gnt;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          exp_sreq;
        logic [N-1:0]  exp_gnt;
        logic [AW-1:0] exp_addr;
        logic [N-1:0]  exp_rv;
        logic [DW-1:0] exp_rd0;
        logic [DW-1:0] exp_rd1;
    } vec_t;

    vec_t vecs[16];

    // ---------------- reference model state ----------------
    int mdl_ptr;
    bit mdl_lock;
    int mdl_lock_idx;
    int mdl_q[$];
    bit mdl_err;

    logic [AW-1:0] a_v[N];
    logic [DW-1:0] d_v[N];
    logic [BW-1:0] b_v[N];
    logic [N-1:0]  w_v;

    initial begin
        fixed_fields();
        drive(2'b11, 1'b1, 1'b1, 32'hCAFE_F00D);

        // Reset: outputs must read zero even with inputs active.
        #2;
        check("rst sreq", s_req_o, 0);
        check("rst gnt", m_gnt_o, 0);
        check("rst rvalid", m_rvalid_o, 0);
        check("rst addr", s_addr_o, 0);
        check("rst rdata", m_rdata_o, 0);
        check("rst err", err_o, 0);
        step();
        drive(2'b00, 1'b0, 1'b0, '0);
        step();
        rst_n = 1'b1;
        step();

        // single master, round robin, lock, FIFO full
        vecs[0]  = '{2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0};
        vecs[1]  = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 2'b00, 32'h0,   2'b01, 32'hDEADBEEF,  32'h0};
        vecs[2]  = '{2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 32'h200, 2'b00, 32'h0,         32'h0};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 32'h11111111,  1'b1, 2'b01, 32'h100, 2'b10, 32'h0,         32'h11111111};
        vecs[4]  = '{2'b11, 1'b1, 1'b1, 32'h22222222,  1'b1, 2'b10, 32'h200, 2'b01, 32'h22222222,  32'h0};
        vecs[5]  = '{2'b00, 1'b0, 1'b1, 32'h33333333,  1'b0, 2'b00, 32'h0,   2'b10, 32'h0,         32'h33333333};
        vecs[6]  = '{2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0};
        vecs[7]  = '{2'b01, 1'b0, 1'b1, 32'h44444444,  1'b1, 2'b00, 32'h100, 2'b01, 32'h44444444,  32'h0};
        vecs[8]  = '{2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 2'b00, 32'h100, 2'b00, 32'h0,         32'h0};
        vecs[9]  = '{2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 2'b00, 32'h100, 2'b00, 32'h0,         32'h0};
        vecs[10] = '{2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 32'h100, 2'b00, 32'h0,         32'h0};
        vecs[11] = '{2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 32'h200, 2'b00, 32'h0,         32'h0};
        vecs[12] = '{2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0,   2'b00, 32'h0,         32'h0};
        vecs[13] = '{2'b11, 1'b1, 1'b1, 32'h55555555,  1'b0, 2'b00, 32'h0,   2'b01, 32'h55555555,  32'h0};
        vecs[14] = '{2'b11, 1'b1, 1'b1, 32'h66666666,  1'b1, 2'b01, 32'h100, 2'b10, 32'h0,         32'h66666666};
        vecs[15] = '{2'b00, 1'b0, 1'b1, 32'h77777777,  1'b0, 2'b00, 32'h0,   2'b01, 32'h77777777,  32'h0};

        for (int r = 0; r < 16; r++) begin
            drive(vecs[r].req, vecs[r].gnt, vecs[r].rv, vecs[r].rdata);
            #1;
            check($sformatf("row%0d sreq", r), s_req_o, vecs[r].exp_sreq);
            check($sformatf("row%0d gnt", r), m_gnt_o, vecs[r].exp_gnt);
            check($sformatf("row%0d addr", r), s_addr_o, vecs[r].exp_addr);
            check($sformatf("row%0d rvalid", r), m_rvalid_o, vecs[r].exp_rv);
            check($sformatf("row%0d rdata0", r), m_rdata_o[DW-1:0], vecs[r].exp_rd0);
            check($sformatf("row%0d rdata1", r), m_rdata_o[2*DW-1:DW], vecs[r].exp_rd1);
            check($sformatf("row%0d err", r), err_o, 0);
            step();
        end

        // Stray response: dropped, err set and held until reset.
        drive(2'b00, 1'b0, 1'b1, 32'h99999999);
        #1;
        check("stray rvalid", m_rvalid_o, 0);
        check("stray err before edge", err_o, 0);
        step();
        drive(2'b00, 1'b0, 1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stray err held %0d", c), err_o, 1);
            step();
        end
        rst_n = 1'b0;
        #1;
        check("stray err cleared by reset", err_o, 0);
        step();
        rst_n = 1'b1;
        step();

        // Reset with two outstanding IDs (head is master 1).
        drive(2'b10, 1'b1, 1'b0, '0);
        #1;
        check("midrst issue m1", m_gnt_o, 2'b10);
        step();
        drive(2'b01, 1'b1, 1'b0, '0);
        #1;
        check("midrst issue m0", m_gnt_o, 2'b01);
        step();
        rst_n = 1'b0;
        drive(2'b11, 1'b1, 1'b1, 32'h12345678);
        #1;
        check("midrst sreq", s_req_o, 0);
        check("midrst gnt", m_gnt_o, 0);
        check("midrst rvalid", m_rvalid_o, 0);
        check("midrst rdata", m_rdata_o, 0);
        check("midrst addr", s_addr_o, 0);
        step();
        rst_n = 1'b1;
        drive(2'b11, 1'b1, 1'b0, '0);
        #1;
        check("post-rst gnt ptr0", m_gnt_o, 2'b01);
        check("post-rst addr", s_addr_o, 32'h100);
        step();
        drive(2'b00, 1'b0, 1'b1, 32'h88888888);
        #1;
        check("post-rst rvalid to m0", m_rvalid_o, 2'b01);
        check("post-rst rdata0", m_rdata_o[DW-1:0], 32'h88888888);
        step();
        #1;
        check("post-rst stray rvalid", m_rvalid_o, 0);
        step();
        drive(2'b00, 1'b0, 1'b0, '0);
        #1;
        check("post-rst late err", err_o, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic against the reference model.
        mdl_ptr = 0; mdl_lock = 0; mdl_lock_idx = 0; mdl_q.delete(); mdl_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N-1:0] req;
            logic gnt, rv;
            logic [DW-1:0] rd;
            int win;
            bit sreq;
            logic [N-1:0] e_gnt, e_rv;
            logic [N*DW-1:0] e_rdata;

            req = N'($urandom_range(0, 3));
            gnt = 1'($urandom_range(0, 1));
            rv  = (mdl_q.size() > 0) && ($urandom_range(0, 2) != 0);
            rd  = $urandom;
            for (int i = 0; i < N; i++) begin
                a_v[i] = $urandom;
                d_v[i] = $urandom;
                b_v[i] = BW'($urandom_range(0, 15));
                w_v[i] = 1'($urandom_range(0, 1));
                m_addr_i[i*AW +: AW]  = a_v[i];
                m_wdata_i[i*DW +: DW] = d_v[i];
                m_be_i[i*BW +: BW]    = b_v[i];
            end
            m_we_i = w_v;
            drive(req, gnt, rv, rd);

            win = -1;
            if (mdl_lock && req[mdl_lock_idx]) begin
                win = mdl_lock_idx;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req[(mdl_ptr + k) % N]) win = (mdl_ptr + k) % N;
                end
            end
            sreq    = (win >= 0) && (mdl_q.size() < MO);
            e_gnt   = (sreq && gnt) ? N'(1 << win) : '0;
            e_rv    = '0;
            e_rdata = '0;
            if (rv && mdl_q.size() > 0) begin
                e_rv[mdl_q[0]] = 1'b1;
                e_rdata[mdl_q[0]*DW +: DW] = rd;
            end

            #1;
            check("rnd sreq", s_req_o, sreq);
            check("rnd gnt", m_gnt_o, e_gnt);
            check("rnd addr", s_addr_o, sreq ? a_v[win] : '0);
            check("rnd we", s_we_o, sreq ? w_v[win] : 1'b0);
            check("rnd be", s_be_o, sreq ? b_v[win] : '0);
            check("rnd wdata", s_wdata_o, sreq ? d_v[win] : '0);
            check("rnd rvalid", m_rvalid_o, e_rv);
            check("rnd rdata", m_rdata_o, e_rdata);
            check("rnd err", err_o, mdl_err);

            // Advance the model across the clock edge.
            if (rv) begin
                if (mdl_q.size() > 0) void'(mdl_q.pop_front());
                else mdl_err = 1;
            end
            if (sreq && gnt) begin
                mdl_q.push_back(win);
                mdl_ptr = (win + 1) % N;
            end
            mdl_lock = sreq && !gnt;
            if (mdl_lock) mdl_lock_idx = win;
            step();
        end

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
